// File: rtl/rx_intf_pkg.sv
// Shared definitions for the rx_intf single-rail to dual-rail NoC transmitter.
package rx_intf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_NULL = 2'b10
    } state_t;

    // Spacer value of one dual-rail bit pair; a full NULL codeword repeats it.
    localparam logic [1:0] NULL_PAIR = 2'b00;

endpackage : rx_intf_pkg

// File: rtl/rx_intf_dr_encode.sv
// Combinational single-rail to dual-rail encoder: bit j -> {data[j], ~data[j]}.
module dr_encode #(
    parameter int unsigned NOC_WID = 16
) (
    input  logic [NOC_WID-1:0]   data_i,
    output logic [2*NOC_WID-1:0] code_o
);

    // Each bit drives its true rail high for 1 and its false rail high for 0.
    always_comb begin
        code_o = '0;
        for (int unsigned j = 0; j < NOC_WID; j++) begin
            code_o[2*j+1] = data_i[j];
            code_o[2*j]   = ~data_i[j];
        end
    end

endmodule : dr_encode

// File: rtl/rx_intf.sv
// rx_intf: buffers a single-rail word and sends it to the NoC as a dual-rail
// codeword under a 4-phase return-to-zero handshake on rx_ack.
// Optional macro RX_INTF_ACK_SYNC_EN inserts a 2-flop synchronizer on rx_ack.
module rx_intf
    import rx_intf_pkg::*;
#(
    parameter int unsigned NOC_WID = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NOC_WID-1:0]   rx,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [2*NOC_WID-1:0] rx_d,
    input  logic                 rx_ack
);

    localparam int unsigned DR_WID = 2 * NOC_WID;
    localparam logic [DR_WID-1:0] NULL_CW = {NOC_WID{NULL_PAIR}};

    state_t             state_q;
    logic               buf_valid_q;
    logic [NOC_WID-1:0] buf_q;
    logic [DR_WID-1:0]  rx_d_q;
    logic [DR_WID-1:0]  buf_code;
    logic               ack_s;

`ifdef RX_INTF_ACK_SYNC_EN
    logic [1:0] ack_sync_q;

    // Two-stage synchronizer for the asynchronous NoC acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync_q <= 2'b00;
        end else begin
            ack_sync_q <= {ack_sync_q[0], rx_ack};
        end
    end

    assign ack_s = ack_sync_q[1];
`else
    assign ack_s = rx_ack;
`endif

    dr_encode #(
        .NOC_WID (NOC_WID)
    ) u_dr_encode (
        .data_i (buf_q),
        .code_o (buf_code)
    );

    // Buffer is free exactly when it holds no word, so drain and accept never collide.
    assign rx_ready = ~buf_valid_q;
    assign rx_d     = rx_d_q;

    // Holding buffer capture plus the IDLE/DATA/NULL handshake sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            rx_d_q      <= NULL_CW;
        end else begin
            if (rx_valid && rx_ready) begin
                buf_q       <= rx;
                buf_valid_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (buf_valid_q) begin
                        rx_d_q      <= buf_code;
                        buf_valid_q <= 1'b0;
                        state_q     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (ack_s) begin
                        rx_d_q  <= NULL_CW;
                        state_q <= ST_NULL;
                    end
                end
                ST_NULL: begin
                    if (!ack_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    rx_d_q  <= NULL_CW;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : rx_intf

// File: tb/tb_rx_intf.sv
// Self-checking bench for rx_intf with NOC_WID=4.
module tb_rx_intf;

    localparam int unsigned W = 4;
`ifdef RX_INTF_ACK_SYNC_EN
    localparam int ACK_LAT = 3;
`else
    localparam int ACK_LAT = 1;
`endif
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_DATA = 2'b01;
    localparam logic [1:0] S_NULL = 2'b10;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   rx;
    logic           rx_valid;
    logic           rx_ready;
    logic [2*W-1:0] rx_d;
    logic           rx_ack;

    int total = 0;
    int bad   = 0;

    rx_intf #(
        .NOC_WID (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_d     (rx_d),
        .rx_ack   (rx_ack)
    );

    always #5 clk = ~clk;

    // Reference dual-rail encoding: true rail carries the bit, false rail its inverse.
    function automatic logic [2*W-1:0] enc(input logic [W-1:0] w);
        logic [2*W-1:0] e;
        for (int j = 0; j < int'(W); j++) begin
            e[2*j+1] = w[j];
            e[2*j]   = ~w[j];
        end
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1; rx = '0; rx_valid = 1'b0; rx_ack = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rx_d !== 8'h00) begin bad++; $display("FAIL reset_rx_d: got %h want 00", rx_d); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", rx_ready); end
        total++; if (2'(dut.state_q) !== S_IDLE) begin bad++; $display("FAIL reset_state: got %b want %b", dut.state_q, S_IDLE); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        rx = 4'b1010; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        total++; if (rx_d !== 8'h00) begin bad++; $display("FAIL single_pre: got %h want 00", rx_d); end
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL single_ready_busy: got %b want 0", rx_ready); end
        @(negedge clk);
        total++; if (rx_d !== 8'b10011001) begin bad++; $display("FAIL single_code: got %h want 99", rx_d); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL single_ready_free: got %b want 1", rx_ready); end
        total++; if (2'(dut.state_q) !== S_DATA) begin bad++; $display("FAIL single_state: got %b want %b", dut.state_q, S_DATA); end
        repeat (3) begin
            @(negedge clk);
            total++; if (rx_d !== 8'h99) begin bad++; $display("FAIL single_hold: got %h want 99", rx_d); end
        end
    endtask

    task automatic test_ack();
        rx_ack = 1'b1;
        for (int k = 1; k <= ACK_LAT; k++) begin
            @(negedge clk);
            total++;
            if (rx_d !== ((k == ACK_LAT) ? 8'h00 : 8'h99)) begin
                bad++; $display("FAIL ack_rise k=%0d: got %h want %h", k, rx_d, (k == ACK_LAT) ? 8'h00 : 8'h99);
            end
        end
        total++; if (2'(dut.state_q) !== S_NULL) begin bad++; $display("FAIL ack_null_state: got %b want %b", dut.state_q, S_NULL); end
        rx_ack = 1'b0;
        for (int k = 1; k <= ACK_LAT; k++) begin
            @(negedge clk);
            total++;
            if (2'(dut.state_q) !== ((k == ACK_LAT) ? S_IDLE : S_NULL)) begin
                bad++; $display("FAIL ack_fall k=%0d: got %b want %b", k, dut.state_q, (k == ACK_LAT) ? S_IDLE : S_NULL);
            end
        end
        total++; if (rx_d !== 8'h00) begin bad++; $display("FAIL ack_fall_null: got %h want 00", rx_d); end
    endtask

    task automatic test_back_to_back();
        rx = 4'h3; rx_valid = 1'b1;
        @(negedge clk);
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_buf: got %b want 0", rx_ready); end
        rx = 4'hC;
        @(negedge clk);
        total++; if (rx_d !== enc(4'h3)) begin bad++; $display("FAIL b2b_first: got %h want %h", rx_d, enc(4'h3)); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_drain: got %b want 1", rx_ready); end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (5) begin
            total++;
            if (rx_d !== enc(4'h3) || rx_ready !== 1'b0) begin
                bad++; $display("FAIL b2b_wait: got d=%h rdy=%b want d=%h rdy=0", rx_d, rx_ready, enc(4'h3));
            end
            @(negedge clk);
        end
        rx_ack = 1'b1;
        for (int k = 1; k <= ACK_LAT; k++) begin
            @(negedge clk);
            total++;
            if (rx_d !== ((k == ACK_LAT) ? 8'h00 : enc(4'h3))) begin
                bad++; $display("FAIL b2b_null k=%0d: got %h", k, rx_d);
            end
        end
        rx_ack = 1'b0;
        for (int k = 1; k <= ACK_LAT; k++) begin
            @(negedge clk);
            total++; if (rx_d !== 8'h00) begin bad++; $display("FAIL b2b_spacer k=%0d: got %h want 00", k, rx_d); end
        end
        @(negedge clk);
        total++; if (rx_d !== enc(4'hC)) begin bad++; $display("FAIL b2b_second: got %h want %h", rx_d, enc(4'hC)); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_end: got %b want 1", rx_ready); end
        rx_ack = 1'b1;
        repeat (ACK_LAT) @(negedge clk);
        total++; if (rx_d !== 8'h00) begin bad++; $display("FAIL b2b_final_null: got %h want 00", rx_d); end
        rx_ack = 1'b0;
        repeat (ACK_LAT) @(negedge clk);
        total++; if (2'(dut.state_q) !== S_IDLE) begin bad++; $display("FAIL b2b_final_idle: got %b want %b", dut.state_q, S_IDLE); end
    endtask

    task automatic test_reset_in_data();
        rx = 4'h5; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        total++; if (rx_d !== enc(4'h5)) begin bad++; $display("FAIL rstd_pre: got %h want %h", rx_d, enc(4'h5)); end
        rx = 4'h6; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (rx_d !== 8'h00) begin bad++; $display("FAIL rstd_d: got %h want 00", rx_d); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rstd_ready: got %b want 1", rx_ready); end
        total++; if (2'(dut.state_q) !== S_IDLE) begin bad++; $display("FAIL rstd_state: got %b want %b", dut.state_q, S_IDLE); end
        repeat (6) begin
            @(negedge clk);
            total++; if (rx_d !== 8'h00) begin bad++; $display("FAIL rstd_spurious: got %h want 00", rx_d); end
        end
    endtask

    task automatic test_ack_idle();
        rx_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (rx_d !== 8'h00 || 2'(dut.state_q) !== S_IDLE || rx_ready !== 1'b1) begin
                bad++; $display("FAIL ack_idle: got d=%h st=%b rdy=%b want d=00 st=00 rdy=1", rx_d, dut.state_q, rx_ready);
            end
        end
        rx_ack = 1'b0;
        repeat (ACK_LAT + 1) @(negedge clk);
    endtask

    // Random producer and NoC responder; scoreboard checks ordering, encoding and NULL spacing.
    task automatic test_random();
        logic [W-1:0]   exp_q[$];
        logic [2*W-1:0] prev_d = '0;
        logic [W-1:0]   acc_word = '0;
        bit             accept_pending = 1'b0;
        bit             producing = 1'b1;
        bit             drained = 1'b0;
        int             ack_dly = 0;
        int             sent = 0;
        int             got = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (accept_pending) begin
                exp_q.push_back(acc_word);
                sent++;
            end
            if (rx_d !== prev_d) begin
                if (rx_d !== 8'h00) begin
                    total++;
                    if (prev_d !== 8'h00 || exp_q.size() == 0 || rx_d !== enc(exp_q[0])) begin
                        bad++;
                        $display("FAIL rand_word: got %h prev %h want %h", rx_d, prev_d,
                                 (exp_q.size() == 0) ? 8'hxx : enc(exp_q[0]));
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    got++;
                end else begin
                    total++;
                    if (rx_ack !== 1'b1) begin bad++; $display("FAIL rand_null_noack: got ack %b want 1", rx_ack); end
                end
                prev_d = rx_d;
            end
            if (!rx_ack && rx_d !== 8'h00) begin
                if (ack_dly == 0) begin rx_ack = 1'b1; ack_dly = int'($urandom_range(0, 3)); end
                else ack_dly--;
            end else if (rx_ack && rx_d === 8'h00) begin
                if (ack_dly == 0) begin rx_ack = 1'b0; ack_dly = int'($urandom_range(0, 3)); end
                else ack_dly--;
            end
            if (cyc >= 400) producing = 1'b0;
            if (accept_pending || !rx_valid) begin
                if (producing && $urandom_range(0, 2) != 0) begin
                    rx = W'($urandom);
                    rx_valid = 1'b1;
                end else begin
                    rx_valid = 1'b0;
                end
            end
            accept_pending = rx_valid && rx_ready;
            acc_word = rx;
            if (!producing && !rx_valid && !accept_pending && exp_q.size() == 0
                && rx_d === 8'h00 && !rx_ack) begin
                drained = 1'b1;
                break;
            end
        end
        total++; if (!drained) begin bad++; $display("FAIL rand_drain: got pending=%0d want 0 within budget", exp_q.size()); end
        total++; if (got != sent) begin bad++; $display("FAIL rand_count: got %0d words want %0d", got, sent); end
        repeat (ACK_LAT + 2) @(negedge clk);
        total++; if (2'(dut.state_q) !== S_IDLE) begin bad++; $display("FAIL rand_end_state: got %b want %b", dut.state_q, S_IDLE); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ack();
        test_back_to_back();
        test_reset_in_data();
        test_ack_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rx_intf

// File: doc/rx_intf.md
RX_INTF -- requirements
Module: rx_intf

Interface
REQ-001 Parameter NOC_WID, default 16: single-rail data width; NoC dual-rail width is 2*NOC_WID.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx  input  NOC_WID  single-rail word from local logic.
REQ-005 rx_valid  input  1  rx holds a word to send.
REQ-006 rx_ready  output  1  block can accept a word this cycle.
REQ-007 rx_d  output  2*NOC_WID  dual-rail codeword toward NoC, registered.
REQ-008 rx_ack  input  1  NoC acknowledge, 4-phase return-to-zero.

Function
REQ-009 The block SHALL encode bit j as rx_d[2j+1]=rx[j] and rx_d[2j]=~rx[j]; NULL is both rails 0 for every j.
REQ-010 A transfer SHALL occur on an edge where rx_valid && rx_ready; rx is captured into a one-entry holding buffer and buf_valid is set.
REQ-011 rx_ready SHALL equal ~buf_valid, a combinational function of registered state only.
REQ-012 FSM states SHALL be IDLE, DATA and NULL.
REQ-013 In IDLE with buf_valid=1, the next edge SHALL load rx_d with the encoded buffer, clear buf_valid, and enter DATA.
REQ-014 In DATA, rx_d SHALL be held stable; when sampled rx_ack=1, the next edge SHALL drive rx_d to NULL and enter NULL.
REQ-015 In NULL, when sampled rx_ack=0, the next edge SHALL enter IDLE.
REQ-016 Latency SHALL be: accept at edge N; rx_d valid after edge N+1 when FSM was IDLE with the buffer empty.
REQ-017 Accept may occur in any state, so the next word is buffered while DATA/NULL is in progress.
REQ-018 rx_d SHALL never change directly from one valid codeword to another; NULL SHALL always intervene.
REQ-019 rx_ack=1 in IDLE SHALL be ignored.
REQ-020 rx_ack=0 in DATA SHALL hold DATA indefinitely; there is no timeout.
REQ-021 rx_valid with rx_ready=0 SHALL leave the buffer unchanged.
REQ-022 The drain (REQ-013) and accept SHALL never coincide, because rx_ready=0 whenever buf_valid=1.

Reset
REQ-023 rst=1 SHALL set FSM=IDLE, buf_valid=0, rx_d=0 (NULL) and rx_ready=1 after the edge, regardless of state.
REQ-024 A reset during DATA SHALL abandon the word, with rx_d=NULL on the following cycle.
REQ-025 The holding buffer data SHALL be cleared to 0 by reset.

Configuration
REQ-026 Macro RX_INTF_ACK_SYNC_EN defined: rx_ack SHALL pass through a 2-flop synchronizer, reset to 0, before FSM use, adding 2 cycles to each ack edge response.
REQ-027 Macro RX_INTF_ACK_SYNC_EN undefined: the FSM SHALL sample rx_ack directly.

Structure
REQ-028 A shared package SHALL hold the FSM state encodings (IDLE=2'b00, DATA=2'b01, NULL=2'b10) and the NULL-codeword constant.
REQ-029 The dual-rail encoder SHALL be a combinational sub-module named dr_encode, parameterised by NOC_WID.
REQ-030 The synchronizer SHALL be inline, generated only under RX_INTF_ACK_SYNC_EN.

Verification (NOC_WID=4, macro undefined unless stated)
REQ-031 Stimulus: rx=4'b1010, one rx_valid pulse. Response: rx_d=8'b10011001 one cycle after accept.
REQ-032 Stimulus: raise rx_ack. Response: rx_d=8'h00 on the next cycle. Then drop rx_ack. Response: state returns to IDLE on the next cycle.
REQ-033 Stimulus: rx_valid held high with words 4'h3 then 4'hC, rx_ack held low. Response: 4'h3 is driven, 4'hC is buffered, rx_ready=0 until 4'h3 completes its handshake; rx_d passes through 00 between codewords.
REQ-034 Stimulus: rst asserted while in DATA. Response: rx_d=0, rx_ready=1, state IDLE on the next cycle, and no spurious codeword afterwards.
REQ-035 Stimulus: rx_ack=1 while IDLE and the buffer is empty. Response: no state change and rx_d stays 0.
REQ-036 Stimulus: repeat REQ-031/032 with RX_INTF_ACK_SYNC_EN defined. Response: NULL appears 3 cycles after the rx_ack rise.
